// File: rtl/multiport_register_file.sv
// Register file with one write port, two registered read ports (A/B), same-cycle
// write-to-read bypass, optional hardwired zero register and a sequenced bulk clear.
module multiport_register_file #(
    parameter  int P_RegCount = 8,
    parameter  int P_BitWidth = 32,
    parameter  int P_ZeroReg  = 1,
    localparam int AW         = (P_RegCount > 1) ? $clog2(P_RegCount) : 1
) (
    input  logic                  In_Clock,
    input  logic                  In_Reset,
    input  logic [AW-1:0]         In_WriteAddress,
    input  logic [P_BitWidth-1:0] In_WriteData,
    input  logic                  In_Write,
    input  logic [AW-1:0]         In_ReadAddressA,
    input  logic                  In_ReadA,
    input  logic [AW-1:0]         In_ReadAddressB,
    input  logic                  In_ReadB,
    input  logic                  In_Clear,
    output logic [P_BitWidth-1:0] Out_ReadDataA,
    output logic                  Out_ValidA,
    output logic [P_BitWidth-1:0] Out_ReadDataB,
    output logic                  Out_ValidB,
    output logic                  Out_Busy,
    output logic                  Out_WriteErr,
    output logic                  Out_DebugState
);

    // Handshake: a read request sampled at a rising edge yields data with Valid=1
    // for the following cycle only; there is no back-pressure on either port.

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [AW:0]   REG_COUNT = (AW + 1)'(P_RegCount);
    localparam logic [AW-1:0] LAST_IDX  = AW'(P_RegCount - 1);

    state_t                  state;
    logic [AW-1:0]           clr_cnt;
    logic [P_BitWidth-1:0]   regs [P_RegCount];

    logic                    wr_range;
    logic                    wr_blocked;
    logic                    wr_accept;
    logic                    wr_error;
    logic [P_BitWidth-1:0]   rd_value_a;
    logic [P_BitWidth-1:0]   rd_value_b;

    function automatic logic in_range(input logic [AW-1:0] addr);
        return {1'b0, addr} < REG_COUNT;
    endfunction

    function automatic logic is_zero_reg(input logic [AW-1:0] addr);
        return (P_ZeroReg != 0) && (addr == '0);
    endfunction

    // Read mux: out-of-range and zero register read 0; an accepted write or the
    // entry being cleared this cycle is forwarded so reads never see stale data.
    function automatic logic [P_BitWidth-1:0] read_value(input logic [AW-1:0] addr);
        logic [P_BitWidth-1:0] value;
        value = '0;
        if (!in_range(addr) || is_zero_reg(addr)) begin
            value = '0;
        end else if (wr_accept && (addr == In_WriteAddress)) begin
            value = In_WriteData;
        end else if ((state == ST_CLEAR) && (addr == clr_cnt)) begin
            value = '0;
        end else begin
            value = regs[addr];
        end
        return value;
    endfunction

    always_comb begin
        wr_range   = in_range(In_WriteAddress);
        wr_blocked = (state == ST_CLEAR) || In_Clear;
        wr_accept  = In_Write && !wr_blocked && wr_range && !is_zero_reg(In_WriteAddress);
        wr_error   = In_Write && (wr_blocked || !wr_range);
        rd_value_a = read_value(In_ReadAddressA);
        rd_value_b = read_value(In_ReadAddressB);
    end

    assign Out_DebugState = state;

    always_ff @(posedge In_Clock or posedge In_Reset) begin
        if (In_Reset) begin
            state         <= ST_IDLE;
            clr_cnt       <= '0;
            Out_Busy      <= 1'b0;
            Out_WriteErr  <= 1'b0;
            Out_ReadDataA <= '0;
            Out_ValidA    <= 1'b0;
            Out_ReadDataB <= '0;
            Out_ValidB    <= 1'b0;
            for (int i = 0; i < P_RegCount; i++) begin
                regs[i] <= '0;
            end
        end else begin
            Out_WriteErr <= wr_error;

            if (wr_accept) begin
                regs[In_WriteAddress] <= In_WriteData;
            end

            case (state)
                ST_IDLE: begin
                    if (In_Clear) begin
                        state    <= ST_CLEAR;
                        clr_cnt  <= '0;
                        Out_Busy <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    regs[clr_cnt] <= '0;
                    if (clr_cnt == LAST_IDX) begin
                        state    <= ST_IDLE;
                        clr_cnt  <= '0;
                        Out_Busy <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    clr_cnt  <= '0;
                    Out_Busy <= 1'b0;
                end
            endcase

            Out_ValidA <= In_ReadA;
            if (In_ReadA) begin
                Out_ReadDataA <= rd_value_a;
            end

            Out_ValidB <= In_ReadB;
            if (In_ReadB) begin
                Out_ReadDataB <= rd_value_b;
            end
        end
    end

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench for multiport_register_file: an 8-entry instance with zero register
// and a 6-entry instance for non-power-of-two addressing.
module tb_multiport_register_file;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // 8-entry instance
    logic [2:0]  waddr, ra_addr, rb_addr;
    logic [31:0] wdata;
    logic        we, ra, rb, clr;
    logic [31:0] rda, rdb;
    logic        va, vb, busy, werr, dstate;

    // 6-entry instance
    logic [2:0]  waddr6, ra_addr6, rb_addr6;
    logic [31:0] wdata6;
    logic        we6, ra6, rb6, clr6;
    logic [31:0] rda6, rdb6;
    logic        va6, vb6, busy6, werr6, dstate6;

    int errors = 0;
    int checks = 0;
    int n;
    logic [31:0] model [8];
    logic [31:0] exp_q [$];

    multiport_register_file #(.P_RegCount(8), .P_BitWidth(32), .P_ZeroReg(1)) u8 (
        .In_Clock(clk), .In_Reset(rst),
        .In_WriteAddress(waddr), .In_WriteData(wdata), .In_Write(we),
        .In_ReadAddressA(ra_addr), .In_ReadA(ra),
        .In_ReadAddressB(rb_addr), .In_ReadB(rb),
        .In_Clear(clr),
        .Out_ReadDataA(rda), .Out_ValidA(va),
        .Out_ReadDataB(rdb), .Out_ValidB(vb),
        .Out_Busy(busy), .Out_WriteErr(werr), .Out_DebugState(dstate)
    );

    multiport_register_file #(.P_RegCount(6), .P_BitWidth(32), .P_ZeroReg(1)) u6 (
        .In_Clock(clk), .In_Reset(rst),
        .In_WriteAddress(waddr6), .In_WriteData(wdata6), .In_Write(we6),
        .In_ReadAddressA(ra_addr6), .In_ReadA(ra6),
        .In_ReadAddressB(rb_addr6), .In_ReadB(rb6),
        .In_Clear(clr6),
        .Out_ReadDataA(rda6), .Out_ValidA(va6),
        .Out_ReadDataB(rdb6), .Out_ValidB(vb6),
        .Out_Busy(busy6), .Out_WriteErr(werr6), .Out_DebugState(dstate6)
    );

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write8(input logic [2:0] a, input logic [31:0] d, input logic exp_err);
        we = 1'b1; waddr = a; wdata = d;
        step();
        we = 1'b0;
        check($sformatf("werr8_a%0d", a), 32'(werr), 32'(exp_err));
    endtask

    task automatic write6(input logic [2:0] a, input logic [31:0] d, input logic exp_err);
        we6 = 1'b1; waddr6 = a; wdata6 = d;
        step();
        we6 = 1'b0;
        check($sformatf("werr6_a%0d", a), 32'(werr6), 32'(exp_err));
    endtask

    task automatic read_all_zero8(input string tag);
        for (int i = 0; i < 8; i++) begin
            ra = 1'b1; ra_addr = 3'(i);
            rb = 1'b1; rb_addr = 3'(7 - i);
            step();
            check($sformatf("%s_a%0d", tag, i), rda, 32'h0);
            check($sformatf("%s_b%0d", tag, 7 - i), rdb, 32'h0);
        end
        ra = 1'b0; rb = 1'b0;
    endtask

    // scoreboard reference for one read in the random phase
    function automatic logic [31:0] model_read(input logic [2:0] a, input logic w,
                                              input logic [2:0] wa, input logic [31:0] wd);
        if (a == 3'd0) return 32'h0;
        if (w && (wa == a)) return wd;
        return model[a];
    endfunction

    initial begin
        we = 0; waddr = 0; wdata = 0; ra = 0; ra_addr = 0; rb = 0; rb_addr = 0; clr = 0;
        we6 = 0; waddr6 = 0; wdata6 = 0; ra6 = 0; ra_addr6 = 0; rb6 = 0; rb_addr6 = 0; clr6 = 0;

        // reset state
        step();
        check("rst_rda", rda, 32'h0);
        check("rst_va", 32'(va), 32'h0);
        check("rst_vb", 32'(vb), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_werr", 32'(werr), 32'h0);
        check("rst_state", 32'(dstate), 32'h0);
        rst = 1'b0;
        step();

        // T1: reset in the middle of a clear sequence
        for (int i = 1; i < 8; i++) write8(3'(i), 32'h1000_0000 + 32'(i), 1'b0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("t1_busy_rise", 32'(busy), 32'h1);
        check("t1_state_clear", 32'(dstate), 32'h1);
        step();
        step();
        rst = 1'b1;
        #1;
        check("t1_busy_reset", 32'(busy), 32'h0);
        check("t1_state_reset", 32'(dstate), 32'h0);
        step();
        rst = 1'b0;
        step();
        read_all_zero8("t1_zero");

        // T2: write then read one cycle later
        write8(3'd3, 32'hDEAD_BEEF, 1'b0);
        ra = 1'b1; ra_addr = 3'd3;
        step();
        check("t2_rda", rda, 32'hDEAD_BEEF);
        check("t2_va", 32'(va), 32'h1);
        ra = 1'b0;
        step();
        check("t2_va_drop", 32'(va), 32'h0);
        check("t2_rda_hold", rda, 32'hDEAD_BEEF);

        // T3: bypass on both ports, then zero-register write
        we = 1'b1; waddr = 3'd5; wdata = 32'h0000_1234;
        rb = 1'b1; rb_addr = 3'd5;
        ra = 1'b1; ra_addr = 3'd5;
        step();
        check("t3_bypass_b", rdb, 32'h0000_1234);
        check("t3_bypass_a", rda, 32'h0000_1234);
        rb = 1'b0;
        waddr = 3'd0; wdata = 32'hFFFF_FFFF; ra_addr = 3'd0;
        step();
        we = 1'b0;
        check("t3_zero_bypass", rda, 32'h0);
        check("t3_zero_werr", 32'(werr), 32'h0);
        step();
        check("t3_zero_stored", rda, 32'h0);
        ra_addr = 3'd5;
        step();
        check("t3_r5_stored", rda, 32'h0000_1234);
        ra = 1'b0;

        // T4: fill, clear, busy length, write during busy, reads during clear
        for (int i = 0; i < 8; i++) write8(3'(i), 32'hA5A5_A5A5, 1'b0);
        ra = 1'b1; ra_addr = 3'd7;
        step();
        ra = 1'b0;
        check("t4_prefill_r7", rda, 32'hA5A5_A5A5);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("t4_busy_rise", 32'(busy), 32'h1);
        n = 0;
        while (busy === 1'b1 && n < 20) begin
            n++;
            clr = (n == 5);
            we = (n == 3); waddr = 3'd4; wdata = 32'h7777_7777;
            ra = (n == 1); ra_addr = 3'd6;
            rb = (n == 8); rb_addr = 3'd7;
            step();
            if (n == 3) check("t4_werr_busy", 32'(werr), 32'h1);
            if (n == 1) check("t4_read_uncleared", rda, 32'hA5A5_A5A5);
            if (n == 8) begin
                check("t4_read_clearing", rdb, 32'h0);
                check("t4_valid_clearing", 32'(vb), 32'h1);
            end
        end
        clr = 1'b0; we = 1'b0; ra = 1'b0; rb = 1'b0;
        check("t4_busy_len", 32'(n), 32'd8);
        read_all_zero8("t4_zero");

        // T5: 6-entry instance, out-of-range writes and reads
        write6(3'd5, 32'h0000_0055, 1'b0);
        write6(3'd7, 32'hBAD0_0007, 1'b1);
        write6(3'd6, 32'hBAD0_0006, 1'b1);
        ra6 = 1'b1; ra_addr6 = 3'd5;
        rb6 = 1'b1; rb_addr6 = 3'd6;
        step();
        check("t5_r5", rda6, 32'h0000_0055);
        check("t5_r6_data", rdb6, 32'h0);
        check("t5_r6_valid", 32'(vb6), 32'h1);
        ra_addr6 = 3'd7; rb_addr6 = 3'd4;
        step();
        check("t5_r7_data", rda6, 32'h0);
        check("t5_r7_valid", 32'(va6), 32'h1);
        check("t5_r4", rdb6, 32'h0);
        ra6 = 1'b0; rb6 = 1'b0;
        clr6 = 1'b1;
        step();
        clr6 = 1'b0;
        n = 0;
        while (busy6 === 1'b1 && n < 20) begin
            n++;
            step();
        end
        check("t5_busy_len6", 32'(n), 32'd6);

        // T6: dual-port random traffic against a scoreboard
        for (int i = 0; i < 8; i++) model[i] = 32'h0;
        for (int c = 0; c < 16; c++) begin
            we = 1'($urandom_range(0, 1));
            waddr = 3'($urandom_range(0, 7));
            wdata = $urandom;
            ra = 1'b1; rb = 1'b1;
            ra_addr = (c % 2 == 0) ? waddr : 3'($urandom_range(0, 7));
            rb_addr = ra_addr + 3'($urandom_range(1, 7));
            exp_q.push_back(model_read(ra_addr, we, waddr, wdata));
            exp_q.push_back(model_read(rb_addr, we, waddr, wdata));
            if (we && waddr != 3'd0) model[waddr] = wdata;
            step();
            check($sformatf("t6_a_c%0d", c), rda, exp_q.pop_front());
            check($sformatf("t6_b_c%0d", c), rdb, exp_q.pop_front());
            check($sformatf("t6_valid_c%0d", c), {30'h0, va, vb}, 32'h3);
            check($sformatf("t6_werr_c%0d", c), 32'(werr), 32'h0);
        end
        we = 1'b0; ra = 1'b0; rb = 1'b0;
        step();
        check("t6_va_idle", 32'(va), 32'h0);

        // final report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
